// File: rtl/sched_pkg.sv
// Shared definitions for the scheduler enqueue path: tuser field positions,
// enqueue FSM encoding and the SUME dst_port to queue-mask decoder.
package sched_pkg;

    localparam int DST_POS       = 24;
    localparam int DROP_POS      = 32;
    localparam int MAX_QUEUE_NUM = 5;
    localparam int DST_FIELD_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENQ  = 2'd1,
        ST_DROP = 2'd2
    } enq_state_t;

    // Even bits of the one-hot field are NF ports; odd (DMA) bits all fold
    // into the last active queue, which is the CPU queue.
    function automatic logic [MAX_QUEUE_NUM-1:0] dst_decode(
        input logic [DST_FIELD_W-1:0] dst_field,
        input int                     queue_num
    );
        logic [MAX_QUEUE_NUM-1:0] mask;
        logic                     cpu_hit;
        mask    = '0;
        cpu_hit = 1'b0;
        for (int i = 0; i < MAX_QUEUE_NUM - 1; i++) begin
            if (i < queue_num - 1) begin
                mask[i] = dst_field[2*i];
                cpu_hit = cpu_hit | dst_field[2*i+1];
            end
        end
        for (int j = 0; j < MAX_QUEUE_NUM; j++) begin
            if (j == queue_num - 1) begin
                mask[j] = cpu_hit;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous reset and clear; clear has
// priority over a same-cycle increment.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/enqueue_agent_v0_2.sv
// Enqueue agent: decides once per packet at SOP which per-port buffers/PIFOs
// receive it, tail-drops or stalls when no destination has room.
module enqueue_agent_v0_2 #(
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int QUEUE_NUM            = 5,
    parameter int DST_POS              = sched_pkg::DST_POS,
    parameter int DROP_POS             = sched_pkg::DROP_POS,
    parameter int STALL_MODE           = 0,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                            axis_aclk,
    input  logic                            axis_reset,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic                            s_axis_tlast,
    input  logic [QUEUE_NUM-1:0]            s_axis_buffer_almost_full,
    output logic [QUEUE_NUM-1:0]            m_axis_ctl_pifo_in_en,
    output logic [QUEUE_NUM-1:0]            m_axis_ctl_buffer_wr_en,
    input  logic                            stats_clear,
    output logic [CNT_WIDTH-1:0]            stat_pkt_drop_cnt,
    output logic [QUEUE_NUM*CNT_WIDTH-1:0]  stat_port_drop_cnt,
    output logic [1:0]                      dbg_state
);
    import sched_pkg::*;

    enq_state_t                 state;
    logic [QUEUE_NUM-1:0]       mask_q;
    logic [MAX_QUEUE_NUM-1:0]   dst_full;
    logic [QUEUE_NUM-1:0]       dst;
    logic [QUEUE_NUM-1:0]       acc;
    logic                       drop_flag;
    logic                       sop_drop;
    logic                       stall;
    logic                       hs;
    logic                       sop_hs;
    logic                       pkt_drop_inc;
    logic [QUEUE_NUM-1:0]       port_drop_inc;
    logic                       unused_tuser;

    assign dst_full     = dst_decode(s_axis_tuser[DST_POS +: DST_FIELD_W], QUEUE_NUM);
    assign dst          = dst_full[QUEUE_NUM-1:0];
    assign acc          = dst & ~s_axis_buffer_almost_full;
    assign drop_flag    = s_axis_tuser[DROP_POS];
    assign sop_drop     = drop_flag || (acc == '0);
    assign unused_tuser = ^{s_axis_tuser, dst_full};

    // A SOP that wants real destinations but finds them all full is held
    // (rather than dropped) only in stall mode.
    assign stall = (STALL_MODE != 0) && s_axis_tvalid && !drop_flag
                   && (dst != '0) && (acc == '0);

    // Handshake: a beat transfers when s_axis_tvalid and s_axis_tready are both
    // high in the same cycle; tready never depends on anything but IDLE-state
    // stall and reset, and every strobe below is qualified by that transfer.
    always_comb begin
        s_axis_tready = 1'b0;
        if (!axis_reset) begin
            if (state == ST_IDLE) begin
                s_axis_tready = !stall;
            end else begin
                s_axis_tready = 1'b1;
            end
        end
    end

    assign hs     = s_axis_tvalid && s_axis_tready;
    assign sop_hs = hs && (state == ST_IDLE);

    always_comb begin
        m_axis_ctl_pifo_in_en   = '0;
        m_axis_ctl_buffer_wr_en = '0;
        pkt_drop_inc            = 1'b0;
        port_drop_inc           = '0;
        if (sop_hs) begin
            if (sop_drop) begin
                pkt_drop_inc = 1'b1;
            end else begin
                m_axis_ctl_pifo_in_en   = acc;
                m_axis_ctl_buffer_wr_en = acc;
                port_drop_inc           = dst & ~acc;
            end
        end else if (hs && (state == ST_ENQ)) begin
            m_axis_ctl_buffer_wr_en = mask_q;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state  <= ST_IDLE;
            mask_q <= '0;
        end else if (hs) begin
            unique case (state)
                ST_IDLE: begin
                    if (sop_drop) begin
                        mask_q <= '0;
                        state  <= s_axis_tlast ? ST_IDLE : ST_DROP;
                    end else begin
                        mask_q <= acc;
                        state  <= s_axis_tlast ? ST_IDLE : ST_ENQ;
                    end
                end
                ST_ENQ, ST_DROP: begin
                    if (s_axis_tlast) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dbg_state = state;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_pkt_drop_cnt (
        .clk (axis_aclk),
        .rst (axis_reset),
        .inc (pkt_drop_inc),
        .clr (stats_clear),
        .q   (stat_pkt_drop_cnt)
    );

    for (genvar i = 0; i < QUEUE_NUM; i++) begin : g_port_cnt
        sat_counter #(.WIDTH(CNT_WIDTH)) u_port_drop_cnt (
            .clk (axis_aclk),
            .rst (axis_reset),
            .inc (port_drop_inc[i]),
            .clr (stats_clear),
            .q   (stat_port_drop_cnt[i*CNT_WIDTH +: CNT_WIDTH])
        );
    end

endmodule

// File: tb/tb_enqueue_agent_v0_2.sv
// Randomized bench for enqueue_agent_v0_2: a tail-drop instance with 4-bit
// counters and a stall-mode instance, both checked against a packet-level model.
module tb_enqueue_agent_v0_2;

    localparam int TW  = 128;
    localparam int QN  = 5;
    localparam int CW0 = 4;
    localparam int CW1 = 32;
    localparam int CMAX0 = (1 << CW0) - 1;

    logic clk = 1'b0;
    logic rst;
    logic stats_clear;
    always #5 clk = ~clk;

    logic               tvalid0, tlast0, tready0;
    logic [TW-1:0]      tuser0;
    logic [QN-1:0]      af0, pifo0, wr0;
    logic [CW0-1:0]     pkt_cnt0;
    logic [QN*CW0-1:0]  port_cnt0;
    logic [1:0]         st0;

    logic               tvalid1, tlast1, tready1;
    logic [TW-1:0]      tuser1;
    logic [QN-1:0]      af1, pifo1, wr1;
    logic [CW1-1:0]     pkt_cnt1;
    logic [QN*CW1-1:0]  port_cnt1;
    logic [1:0]         st1;

    enqueue_agent_v0_2 #(.QUEUE_NUM(QN), .STALL_MODE(0), .CNT_WIDTH(CW0)) dut0 (
        .axis_aclk(clk), .axis_reset(rst),
        .s_axis_tvalid(tvalid0), .s_axis_tready(tready0), .s_axis_tuser(tuser0),
        .s_axis_tlast(tlast0), .s_axis_buffer_almost_full(af0),
        .m_axis_ctl_pifo_in_en(pifo0), .m_axis_ctl_buffer_wr_en(wr0),
        .stats_clear(stats_clear), .stat_pkt_drop_cnt(pkt_cnt0),
        .stat_port_drop_cnt(port_cnt0), .dbg_state(st0)
    );

    enqueue_agent_v0_2 #(.QUEUE_NUM(QN), .STALL_MODE(1), .CNT_WIDTH(CW1)) dut1 (
        .axis_aclk(clk), .axis_reset(rst),
        .s_axis_tvalid(tvalid1), .s_axis_tready(tready1), .s_axis_tuser(tuser1),
        .s_axis_tlast(tlast1), .s_axis_buffer_almost_full(af1),
        .m_axis_ctl_pifo_in_en(pifo1), .m_axis_ctl_buffer_wr_en(wr1),
        .stats_clear(stats_clear), .stat_pkt_drop_cnt(pkt_cnt1),
        .stat_port_drop_cnt(port_cnt1), .dbg_state(st1)
    );

    int n_pass  = 0;
    int n_total = 0;
    int exp_pkt0;
    int exp_port0[QN];
    int exp_pkt1;

    // Destination set of a packet, straight from the dst_port field rules.
    function automatic logic [QN-1:0] model_dst(input logic [7:0] f);
        logic [QN-1:0] d;
        d = '0;
        for (int i = 0; i < QN - 1; i++) begin
            d[i] = f[2*i];
            if (f[2*i+1]) d[QN-1] = 1'b1;
        end
        return d;
    endfunction

    function automatic logic [TW-1:0] make_tuser(input logic [7:0] f, input bit drop);
        logic [TW-1:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        t[24 +: 8] = f;
        t[32] = drop;
        return t;
    endfunction

    function automatic int sat0(input int v);
        return (v > CMAX0) ? CMAX0 : v;
    endfunction

    // Sends one packet to dut0 starting at posedge+1, checks every beat, and
    // returns at posedge+1 after the last beat with counters checked.
    task automatic send_pkt(input string name, input int nbeats, input logic [7:0] f,
                            input bit drop, input logic [QN-1:0] af_sop,
                            input logic [QN-1:0] af_mid);
        logic [QN-1:0] d, a, m;
        bit dropped;
        d = model_dst(f);
        a = d & ~af_sop;
        dropped = drop || (a == '0);
        m = dropped ? '0 : a;
        for (int b = 0; b < nbeats; b++) begin
            tvalid0 = 1'b1;
            tlast0  = (b == nbeats - 1);
            tuser0  = (b == 0) ? make_tuser(f, drop) : {$urandom, $urandom, $urandom, $urandom};
            af0     = (b == 0) ? af_sop : af_mid;
            @(negedge clk);
            n_total++;
            if (tready0 !== 1'b1) $display("FAIL %s tready beat %0d: got %b want 1", name, b, tready0);
            else n_pass++;
            n_total++;
            if (pifo0 !== ((b == 0) ? m : '0))
                $display("FAIL %s pifo_in_en beat %0d: got %b want %b", name, b, pifo0, (b == 0) ? m : '0);
            else n_pass++;
            n_total++;
            if (wr0 !== m) $display("FAIL %s wr_en beat %0d: got %b want %b", name, b, wr0, m);
            else n_pass++;
            @(posedge clk); #1;
        end
        tvalid0 = 1'b0;
        tlast0  = 1'b0;
        if (dropped) exp_pkt0 = sat0(exp_pkt0 + 1);
        else for (int i = 0; i < QN; i++) if (d[i] && !a[i]) exp_port0[i] = sat0(exp_port0[i] + 1);
        n_total++;
        if (pkt_cnt0 !== CW0'(exp_pkt0)) $display("FAIL %s pkt_drop_cnt: got %0d want %0d", name, pkt_cnt0, exp_pkt0);
        else n_pass++;
        for (int i = 0; i < QN; i++) begin
            n_total++;
            if (port_cnt0[i*CW0 +: CW0] !== CW0'(exp_port0[i]))
                $display("FAIL %s port_drop_cnt[%0d]: got %0d want %0d", name, i, port_cnt0[i*CW0 +: CW0], exp_port0[i]);
            else n_pass++;
        end
    endtask

    task automatic clear_model();
        exp_pkt0 = 0;
        exp_pkt1 = 0;
        for (int i = 0; i < QN; i++) exp_port0[i] = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tvalid0 = 1'b1; tuser0 = make_tuser(8'h04, 1'b0); tlast0 = 1'b1; af0 = '0;
        tvalid1 = 1'b1; tuser1 = make_tuser(8'h04, 1'b0); tlast1 = 1'b1; af1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (tready0 !== 1'b0 || tready1 !== 1'b0) $display("FAIL reset_tready: got %b/%b want 0/0", tready0, tready1);
        else n_pass++;
        n_total++;
        if (pifo0 !== '0 || wr0 !== '0 || pifo1 !== '0 || wr1 !== '0)
            $display("FAIL reset_strobes: got %b %b %b %b want all 0", pifo0, wr0, pifo1, wr1);
        else n_pass++;
        n_total++;
        if (pkt_cnt0 !== '0 || port_cnt0 !== '0 || pkt_cnt1 !== '0) $display("FAIL reset_counters: got %0d %h %0d want 0", pkt_cnt0, port_cnt0, pkt_cnt1);
        else n_pass++;
        n_total++;
        if (st0 !== 2'd0 || st1 !== 2'd0) $display("FAIL reset_state: got %0d/%0d want 0/0", st0, st1);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0; tvalid0 = 1'b0; tvalid1 = 1'b0; tlast0 = 1'b0; tlast1 = 1'b0;
        clear_model();
    endtask

    task automatic test_unicast();
        send_pkt("unicast", 3, 8'h04, 1'b0, '0, '0);
        send_pkt("unicast_next_sop", 1, 8'h10, 1'b0, '0, '0);
    endtask

    task automatic test_partial_mcast();
        send_pkt("partial_mcast", 4, 8'h15, 1'b0, 5'b00010, 5'b00011);
    endtask

    task automatic test_drop_flag();
        send_pkt("drop_flag", 4, 8'h04, 1'b1, '0, '0);
        send_pkt("after_drop", 2, 8'h01, 1'b0, '0, '0);
    endtask

    task automatic test_all_full_tail();
        send_pkt("all_full_tail", 2, 8'h02, 1'b0, 5'b10000, 5'b10000);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++)
            send_pkt("b2b_single", 1, (k % 2 == 1) ? 8'h40 : 8'h01, 1'b0, '0, '0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++)
            send_pkt("random", $urandom_range(1, 4), 8'($urandom), ($urandom_range(0, 7) == 0),
                     QN'($urandom), QN'($urandom));
    endtask

    task automatic test_reset_mid();
        tvalid0 = 1'b1; tlast0 = 1'b0; tuser0 = make_tuser(8'h04, 1'b0); af0 = '0;
        @(negedge clk);
        n_total++;
        if (pifo0 !== 5'b00010) $display("FAIL reset_mid_sop pifo_in_en: got %b want 00010", pifo0);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        tuser0 = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        n_total++;
        if (tready0 !== 1'b0 || pifo0 !== '0 || wr0 !== '0)
            $display("FAIL reset_mid_outputs: got tready=%b pifo=%b wr=%b want 0", tready0, pifo0, wr0);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        tvalid0 = 1'b0;
        clear_model();
        n_total++;
        if (st0 !== 2'd0) $display("FAIL reset_mid_state: got %0d want 0", st0);
        else n_pass++;
        send_pkt("post_reset_sop", 2, 8'h40, 1'b0, '0, '0);
    endtask

    task automatic test_stall();
        tvalid1 = 1'b1; tlast1 = 1'b1; tuser1 = make_tuser(8'h02, 1'b0); af1 = 5'b10000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_total++;
            if (tready1 !== 1'b0 || pifo1 !== '0 || wr1 !== '0)
                $display("FAIL stall_hold cycle %0d: got tready=%b pifo=%b wr=%b want 0", c, tready1, pifo1, wr1);
            else n_pass++;
            @(posedge clk); #1;
        end
        af1 = '0;
        @(negedge clk);
        n_total++;
        if (tready1 !== 1'b1 || pifo1 !== 5'b10000 || wr1 !== 5'b10000)
            $display("FAIL stall_release: got tready=%b pifo=%b wr=%b want 1 10000 10000", tready1, pifo1, wr1);
        else n_pass++;
        @(posedge clk); #1;
        // A flagged drop and an empty destination set must pass straight through.
        for (int k = 0; k < 2; k++) begin
            tuser1 = (k == 0) ? make_tuser(8'h02, 1'b1) : make_tuser(8'h00, 1'b0);
            af1 = 5'b11111;
            @(negedge clk);
            n_total++;
            if (tready1 !== 1'b1 || wr1 !== '0 || pifo1 !== '0)
                $display("FAIL stall_nodrop_stall %0d: got tready=%b wr=%b pifo=%b want 1 0 0", k, tready1, wr1, pifo1);
            else n_pass++;
            @(posedge clk); #1;
            exp_pkt1++;
        end
        tvalid1 = 1'b0; tlast1 = 1'b0;
        n_total++;
        if (pkt_cnt1 !== CW1'(exp_pkt1)) $display("FAIL stall_pkt_drop_cnt: got %0d want %0d", pkt_cnt1, exp_pkt1);
        else n_pass++;
    endtask

    task automatic test_counters();
        for (int k = 0; k < 20; k++) send_pkt("sat_drop", 1, 8'h04, 1'b1, '0, '0);
        n_total++;
        if (pkt_cnt0 !== 4'hF) $display("FAIL counter_saturate: got %0d want 15", pkt_cnt0);
        else n_pass++;
        stats_clear = 1'b1;
        tvalid0 = 1'b1; tlast0 = 1'b1; tuser0 = make_tuser(8'h04, 1'b1);
        @(posedge clk); #1;
        stats_clear = 1'b0; tvalid0 = 1'b0; tlast0 = 1'b0;
        clear_model();
        n_total++;
        if (pkt_cnt0 !== '0 || port_cnt0 !== '0 || pkt_cnt1 !== '0)
            $display("FAIL stats_clear: got %0d %h %0d want 0", pkt_cnt0, port_cnt0, pkt_cnt1);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; stats_clear = 1'b0;
        tvalid0 = 1'b0; tlast0 = 1'b0; tuser0 = '0; af0 = '0;
        tvalid1 = 1'b0; tlast1 = 1'b0; tuser1 = '0; af1 = '0;
        clear_model();
        test_reset();
        test_unicast();
        test_partial_mcast();
        test_drop_flag();
        test_all_full_tail();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_stall();
        test_counters();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
